// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared SCCB constants, state encoding and bit-count width
package sccb_pkg;

  localparam logic [6:0] SCCB_DEV_ADDR = 7'h3C;
  localparam int unsigned BIT_CNT_W = 4;
  localparam logic [3:0] LAST_BIT  = 4'd7;
  localparam logic [3:0] ACK_PHASE = 4'd8;

  localparam logic SCCB_ACK  = 1'b0;
  localparam logic SCCB_NACK = 1'b1;

  typedef logic [3:0] sccb_state_t;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_DEV     = 4'd1;
  localparam logic [3:0] ST_ACK_DEV = 4'd2;
  localparam logic [3:0] ST_SUB_HI  = 4'd3;
  localparam logic [3:0] ST_ACK_HI  = 4'd4;
  localparam logic [3:0] ST_SUB_LO  = 4'd5;
  localparam logic [3:0] ST_ACK_LO  = 4'd6;
  localparam logic [3:0] ST_WDATA   = 4'd7;
  localparam logic [3:0] ST_ACK_W   = 4'd8;
  localparam logic [3:0] ST_RDATA   = 4'd9;
  localparam logic [3:0] ST_ACK_R   = 4'd10;
  localparam logic [3:0] ST_IGNORE  = 4'd11;

endpackage

// File: rtl/sccb_target_if.sv
// rtl/sccb_target_if.sv - SCCB pins plus register-file port of the SCCB target
interface sccb_target_if;

  logic        scl_i;
  logic        sda_i;
  logic        sda_oe;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata;
  logic        busy;

  modport slave (
    input  scl_i, sda_i, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

  modport master (
    output scl_i, sda_i, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

endinterface

// File: rtl/sccb_bus_sync.sv
// rtl/sccb_bus_sync.sv - SCL/SDA synchronizer with edge, START and STOP detection
module sccb_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_hist_q, scl_hist_d;
  logic       sda_hist_q, sda_hist_d;
  logic       rise_q, rise_d, fall_q, fall_d;
  logic       start_q, start_d, stop_q, stop_d;
  logic       sda_q, sda_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_hist_d = scl_sync_q[1];
    sda_hist_d = sda_sync_q[1];
    rise_d     = scl_sync_q[1] & ~scl_hist_q;
    fall_d     = ~scl_sync_q[1] & scl_hist_q;
    stop_d     = scl_sync_q[1] & scl_hist_q & sda_sync_q[1] & ~sda_hist_q;
    // STOP wins should a glitch ever make both look true
    start_d    = scl_sync_q[1] & scl_hist_q & ~sda_sync_q[1] & sda_hist_q & ~stop_d;
    sda_d      = sda_sync_q[1];
  end

  // Reset to the idle-high bus so leaving reset creates no spurious edges
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      sda_q      <= sda_d;
    end
  end

  assign scl_rise = rise_q;
  assign scl_fall = fall_q;
  assign start    = start_q;
  assign stop     = stop_q;
  assign sda_s    = sda_q;

endmodule

// File: rtl/sccb_target.sv
// rtl/sccb_target.sv - SCCB target: device/sub-address decode, byte ACK, register-file port
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = SCCB_DEV_ADDR,
  parameter int unsigned RD_LAT   = 2
) (
  input logic          clk,
  input logic          rst,
  sccb_target_if.slave bus
);

  logic scl_rise, scl_fall, start, stop, sda_s;

  sccb_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (bus.scl_i),
    .sda_i    (bus.sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  sccb_state_t          state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [6:0]           rx_q, rx_d;
  logic [7:0]           tx_q, tx_d;
  logic [7:0]           addr_hi_q, addr_hi_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [15:0]          addr_q, addr_d;
  logic [2:0]           rd_cnt_q, rd_cnt_d;
  logic                 rw_q, rw_d;
  logic                 we_q, we_d;
  logic                 re_q, re_d;
  logic                 oe_q, oe_d;
  logic                 busy_q, busy_d;
  logic [7:0]           rx_byte;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_hi_d = addr_hi_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    rd_cnt_d  = rd_cnt_q;
    rw_d      = rw_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    oe_d      = oe_q;
    busy_d    = busy_q;
    rx_byte   = {rx_q, sda_s};

    if (we_q) addr_d = addr_q + 16'd1;

    // Read data lands in the TX register a fixed RD_LAT clks after reg_re
    if (rd_cnt_q != 3'd0) begin
      rd_cnt_d = rd_cnt_q - 3'd1;
      if (rd_cnt_q == 3'd1) tx_d = bus.reg_rdata;
    end
    if (re_q) rd_cnt_d = 3'(RD_LAT);

    if (stop) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d   = ST_DEV;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        ST_DEV, ST_SUB_HI, ST_SUB_LO, ST_WDATA: begin
          if (scl_rise) begin
            rx_d = rx_byte[6:0];
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              case (state_q)
                ST_DEV: begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_d = ST_ACK_DEV;
                    rw_d    = rx_byte[0];
                    re_d    = rx_byte[0];
                    busy_d  = 1'b1;
                  end else begin
                    state_d = ST_IGNORE;
                    busy_d  = 1'b0;
                  end
                end
                ST_SUB_HI: begin
                  addr_hi_d = rx_byte;
                  state_d   = ST_ACK_HI;
                end
                ST_SUB_LO: begin
                  addr_d  = {addr_hi_q, rx_byte};
                  state_d = ST_ACK_LO;
                end
                default: begin
                  we_d    = 1'b1;
                  wdata_d = rx_byte;
                  state_d = ST_ACK_W;
                end
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end

        // ACK_PHASE in bit_cnt marks that the 9th rise has been seen
        ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO, ST_ACK_W: begin
          if (scl_rise) begin
            bit_cnt_d = ACK_PHASE;
          end else if (scl_fall) begin
            if (bit_cnt_q == ACK_PHASE) begin
              bit_cnt_d = '0;
              oe_d      = 1'b0;
              case (state_q)
                ST_ACK_DEV: begin
                  if (rw_q) begin
                    state_d = ST_RDATA;
                    oe_d    = ~tx_q[7];
                    tx_d    = {tx_q[6:0], 1'b0};
                  end else begin
                    state_d = ST_SUB_HI;
                  end
                end
                ST_ACK_HI: state_d = ST_SUB_LO;
                default:   state_d = ST_WDATA;
              endcase
            end else begin
              oe_d = ~SCCB_ACK;
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              state_d   = ST_ACK_R;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if (scl_fall && bit_cnt_q != '0) begin
            oe_d = ~tx_q[7];
            tx_d = {tx_q[6:0], 1'b0};
          end
        end

        ST_ACK_R: begin
          if (scl_rise) begin
            if (sda_s == SCCB_NACK) begin
              state_d = ST_IGNORE;
              oe_d    = 1'b0;
            end else begin
              addr_d    = addr_q + 16'd1;
              re_d      = 1'b1;
              bit_cnt_d = ACK_PHASE;
            end
          end else if (scl_fall) begin
            if (bit_cnt_q == ACK_PHASE) begin
              bit_cnt_d = '0;
              state_d   = ST_RDATA;
              oe_d      = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
            end else begin
              oe_d = 1'b0;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_hi_q <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      rd_cnt_q  <= '0;
      rw_q      <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_hi_q <= addr_hi_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      rd_cnt_q  <= rd_cnt_d;
      rw_q      <= rw_d;
      we_q      <= we_d;
      re_q      <= re_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.sda_oe    = oe_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sccb_target.sv
// tb/tb_sccb_target.sv - bit-banged SCCB master with transaction-level reference model
module tb_sccb_target;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic [7:0] mem [0:65535];

  sccb_target_if bus ();

  assign bus.scl_i     = scl_m;
  assign bus.sda_i     = sda_m & ~bus.sda_oe;
  assign bus.reg_rdata = mem[bus.reg_addr];

  sccb_target #(.DEV_ADDR(7'h3C), .RD_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  wr_t wr_q[$];
  wr_t exp_wr[$];
  logic [15:0] rd_q[$];
  logic [15:0] exp_rd[$];
  int both_cnt = 0;
  int wide_cnt = 0;
  logic prev_we = 1'b0;
  logic prev_re = 1'b0;
  logic oe_seen = 1'b0;
  logic [15:0] model_addr = 16'h0000;

  always @(negedge clk) begin
    if (bus.reg_we) wr_q.push_back({bus.reg_addr, bus.reg_wdata});
    if (bus.reg_re) rd_q.push_back(bus.reg_addr);
    if (bus.reg_we && bus.reg_re) both_cnt++;
    if ((bus.reg_we && prev_we) || (bus.reg_re && prev_re)) wide_cnt++;
    prev_we = bus.reg_we;
    prev_re = bus.reg_re;
    if (bus.sda_oe) oe_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic got);
    wait_clks(8);
    sda_m = b;
    wait_clks(8);
    scl_m = 1'b1;
    wait_clks(8);
    got = bus.sda_i;
    wait_clks(8);
    scl_m = 1'b0;
  endtask

  task automatic bus_start();
    if (!scl_m) begin
      wait_clks(8);
      sda_m = 1'b1;
      wait_clks(8);
      scl_m = 1'b1;
    end
    wait_clks(8);
    sda_m = 1'b0;
    wait_clks(8);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clks(8);
    sda_m = 1'b0;
    wait_clks(8);
    scl_m = 1'b1;
    wait_clks(8);
    sda_m = 1'b1;
    wait_clks(8);
  endtask

  task automatic write_byte(input logic [7:0] b, input int nbits, output logic ack);
    logic s;
    ack = 1'b1;
    for (int i = 0; i < nbits; i++) clk_bit(b[7-i], s);
    if (nbits == 8) clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, b);
      d[i] = b;
    end
    clk_bit(mack, b);
  endtask

  task automatic compare_strobes(input string tag);
    check_eq({tag, "/n_we"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      check_eq({tag, "/we"}, wr_q[i], exp_wr[i]);
    check_eq({tag, "/n_re"}, rd_q.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
      check_eq({tag, "/re_addr"}, rd_q[i], exp_rd[i]);
    wr_q.delete();
    exp_wr.delete();
    rd_q.delete();
    exp_rd.delete();
  endtask

  // Data bytes are taken MSB-first from dat
  task automatic do_write(input logic [15:0] a, input int n, input logic [31:0] dat, input string tag);
    logic ack;
    logic [7:0] d;
    bus_start();
    write_byte(8'h78, 8, ack);
    check_eq({tag, "/ack_dev"}, ack, 1'b0);
    check_eq({tag, "/busy"}, bus.busy, 1'b1);
    write_byte(a[15:8], 8, ack);
    check_eq({tag, "/ack_hi"}, ack, 1'b0);
    write_byte(a[7:0], 8, ack);
    check_eq({tag, "/ack_lo"}, ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      d = dat[31-8*i -: 8];
      write_byte(d, 8, ack);
      check_eq({tag, "/ack_w"}, ack, 1'b0);
      exp_wr.push_back({a + 16'(i), d});
    end
    bus_stop();
    check_eq({tag, "/busy_end"}, bus.busy, 1'b0);
    compare_strobes(tag);
    model_addr = a + 16'(n);
    check_eq({tag, "/addr"}, bus.reg_addr, model_addr);
  endtask

  task automatic do_read(input int n, input string tag);
    logic ack;
    logic [7:0] d;
    logic [15:0] ea;
    bus_start();
    write_byte(8'h79, 8, ack);
    check_eq({tag, "/ack_dev"}, ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      ea = model_addr + 16'(i);
      read_byte(i == n - 1, d);
      check_eq({tag, "/rdata"}, d, mem[ea]);
      exp_rd.push_back(ea);
    end
    check_eq({tag, "/released"}, bus.sda_oe, 1'b0);
    bus_stop();
    check_eq({tag, "/busy_end"}, bus.busy, 1'b0);
    compare_strobes(tag);
    model_addr = model_addr + 16'(n - 1);
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    logic [7:0] d;
    logic [15:0] old_addr;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    wait_clks(5);
    check_eq("rst/sda_oe", bus.sda_oe, 1'b0);
    check_eq("rst/we", bus.reg_we, 1'b0);
    check_eq("rst/re", bus.reg_re, 1'b0);
    check_eq("rst/addr", bus.reg_addr, 16'h0000);
    check_eq("rst/wdata", bus.reg_wdata, 8'h00);
    check_eq("rst/busy", bus.busy, 1'b0);
    rst = 1'b0;
    wait_clks(10);

    do_write(16'h3008, 1, 32'h42000000, "wr1");

    do_write(16'h300A, 0, 32'h0, "setaddr");
    mem[16'h300A] = 8'h56;
    do_read(1, "rd1");

    do_write(16'h1234, 3, 32'hAABBCC00, "burst");

    // Foreign device address: no ACKs, no drive, no strobes
    oe_seen = 1'b0;
    bus_start();
    write_byte(8'h84, 8, ack);
    check_eq("nomatch/ack_dev", ack, 1'b1);
    write_byte(8'h30, 8, ack);
    check_eq("nomatch/ack1", ack, 1'b1);
    write_byte(8'h08, 8, ack);
    check_eq("nomatch/ack2", ack, 1'b1);
    check_eq("nomatch/busy", bus.busy, 1'b0);
    bus_stop();
    check_eq("nomatch/oe_seen", oe_seen, 1'b0);
    compare_strobes("nomatch");

    // Repeated START inside SUB_LO keeps the old sub-address
    old_addr = model_addr;
    bus_start();
    write_byte(8'h78, 8, ack);
    check_eq("rs/ack_dev", ack, 1'b0);
    write_byte(8'h77, 8, ack);
    check_eq("rs/ack_hi", ack, 1'b0);
    write_byte(8'h55, 4, ack);
    bus_start();
    check_eq("rs/addr_kept", bus.reg_addr, old_addr);
    write_byte(8'h79, 8, ack);
    check_eq("rs/ack_rd", ack, 1'b0);
    read_byte(1'b0, d);
    check_eq("rs/rdata0", d, mem[old_addr]);
    read_byte(1'b1, d);
    check_eq("rs/rdata1", d, mem[old_addr + 16'd1]);
    exp_rd.push_back(old_addr);
    exp_rd.push_back(old_addr + 16'd1);
    bus_stop();
    compare_strobes("rs");
    model_addr = old_addr + 16'd1;

    for (int t = 0; t < 8; t++) begin
      if (t == 0) begin
        do_write(16'hFFFF, 2, $urandom, "wrap");
      end else if ($urandom_range(0, 1) == 0) begin
        do_write(16'($urandom), $urandom_range(1, 4), $urandom, "rnd_wr");
      end else begin
        do_read($urandom_range(1, 3), "rnd_rd");
      end
    end

    // Reset while the target is pulling SDA low for a read bit
    mem[model_addr] = 8'h3C;
    bus_start();
    write_byte(8'h79, 8, ack);
    check_eq("rstmid/ack_dev", ack, 1'b0);
    wait_clks(8);
    check_eq("rstmid/driving", bus.sda_oe, 1'b1);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    check_eq("rstmid/oe_off", bus.sda_oe, 1'b0);
    check_eq("rstmid/n_re", rd_q.size(), 1);
    if (rd_q.size() > 0) check_eq("rstmid/re_addr", rd_q[0], model_addr);
    rd_q.delete();
    oe_seen = 1'b0;
    model_addr = 16'h0000;
    write_byte(8'h78, 8, ack);
    check_eq("rstmid/ign_ack1", ack, 1'b1);
    write_byte(8'h00, 8, ack);
    check_eq("rstmid/ign_ack2", ack, 1'b1);
    check_eq("rstmid/addr", bus.reg_addr, model_addr);
    bus_stop();
    check_eq("rstmid/oe_seen", oe_seen, 1'b0);
    compare_strobes("rstmid");
    do_write(16'h0005, 1, 32'h99000000, "after_rst");

    check_eq("strobe_overlap", both_cnt, 0);
    check_eq("strobe_width", wide_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sccb_target.md
# sccb_target

Open-drain I2C/SCCB target (responder) that answers our camera-side SCCB master inside the FPGA. Used as a loopback camera-register model for board bring-up and simulation, and as a host-facing configuration port. It decodes device address, 16-bit sub-address and data bytes, and ACKs each byte. Writes go out, and reads come in, through a simple single-cycle register-file port with sub-address auto-increment.

## Interface
- DEV_ADDR, 7'h3C, 7-bit target address (0x78 write / 0x79 read on the wire)
- RD_LAT, 2, clk cycles from `reg_re` to valid `reg_rdata` (1..4)

Ports:
- clk  in  1  system clock; must be ≥ 16× SCL frequency
- rst  in  1  reset; synchronous, active-high
- scl_i  in  1  raw SCL pin (asynchronous)
- sda_i  in  1  raw SDA pin (asynchronous)
- sda_oe  out  1  1 = pull SDA low; top level drives pin as `sda_oe ? 0 : z`
- reg_addr  out  16  current sub-address
- reg_wdata  out  8  write data, valid with `reg_we`
- reg_we  out  1  one-clk write strobe
- reg_re  out  1  one-clk read strobe
- reg_rdata  in  8  read data, sampled RD_LAT clks after `reg_re`
- busy  out  1  high from START to STOP while addressed

## Operation
- scl_i/sda_i pass through a 2-flop synchronizer and a 1-flop history. Events are derived from these: scl_rise, scl_fall, START (SDA falls while SCL high), STOP (SDA rises while SCL high).
- Bits are sampled on scl_rise. `sda_oe` changes only on scl_fall, one clk after detection.
- States: IDLE, DEV, ACK_DEV, SUB_HI, ACK_HI, SUB_LO, ACK_LO, WDATA, ACK_W, RDATA, ACK_R, IGNORE.
- START from any state: go to DEV and clear the bit counter. This is a repeated start; `reg_addr` is kept.
- STOP from any state: go to IDLE, set `sda_oe`=0 and `busy`=0.
- DEV: shift 8 bits MSB first.
  - Address match: go to ACK_DEV.
  - Mismatch: go to IGNORE. `sda_oe` stays 0 until START/STOP.
- ACK_DEV: drive 0 during the 9th SCL period.
  - Then R/W=0 goes to SUB_HI.
  - R/W=1 goes to RDATA.
- SUB_HI then ACK_HI, SUB_LO then ACK_LO: load `reg_addr` {hi, lo} at the 8th rise of the lo byte. Then go to WDATA.
- WDATA: after 8 bits, pulse `reg_we` with the byte on `reg_wdata`. Go to ACK_W, then WDATA again. `reg_addr` increments by 1 after each write, wrapping 16'hFFFF→0.
- Read path:
  - `reg_re` pulses on the clk after the R/W bit is sampled.
  - `reg_rdata` is captured into the TX shift register RD_LAT clks later.
  - Bit 7 is driven at the ACK_DEV-ending scl_fall.
  - `sda_oe` = ~bit on each scl_fall for 8 bits. Then release and go to ACK_R.
- ACK_R: sample master ACK on the 9th rise.
  - ACK (0): increment `reg_addr`, pulse `reg_re`, go back to RDATA.
  - NACK (1): go to IGNORE and release SDA until STOP.
- No clock stretching; SCL is never driven.

## Timing
- Reset values: `sda_oe`=0, `reg_we`=0, `reg_re`=0, `reg_addr`=0, `reg_wdata`=0, `busy`=0, state IDLE.
- Reset mid-transfer: `sda_oe`=0 on the clk after `rst` is sampled high. The next transfer needs a fresh START.
- Pin-to-event latency is 3 clks. Output change after scl_fall is ≤ 4 clks, which must fit inside the SCL-low half period.
- `reg_we` and `reg_re` are exactly 1 clk wide, never asserted together, and at most one per byte.
- START and STOP in the same clk cannot occur; STOP takes precedence if the synchronizer glitches.
- A STOP inside WDATA before 8 bits discards the partial byte; no `reg_we`.

## Structure
- Shared `sccb_pkg`: state encoding, DEV_ADDR default, bit-count width, and the ACK/NACK constants, so the master and target benches share them.
- Sub-module `sccb_bus_sync`: synchronizer plus edge, START and STOP detection. Outputs scl_rise, scl_fall, start, stop and sda_s.
- The remaining FSM, shift registers and address counter live in `sccb_target` (~250 lines).

## Test plan
- Write 0x78, 0x30, 0x08, 0x42 → 4 ACKs (`sda_oe` low in each 9th period); one `reg_we` with `reg_addr`=0x3008 and `reg_wdata`=0x42.
- Write 0x78, 0x30, 0x0A; STOP; START 0x79 with `reg_rdata`=0x56 → `reg_re` at `reg_addr`=0x300A; SDA carries 0101_0110; master NACK → SDA released; STOP → `busy`=0.
- Burst write 0x78, 0x12, 0x34 followed by 0xAA, 0xBB, 0xCC → three `reg_we` at 0x1234, 0x1235, 0x1236.
- Address 0x42 → no ACK; `sda_oe` stays 0 through the following bytes; no strobes.
- Repeated START after 4 bits of SUB_LO → returns to DEV; `reg_addr` unchanged; next 0x79 read uses the old address.
- `rst` asserted while driving a 0 read bit → `sda_oe`=0 next clk; subsequent bytes ignored until START.
